// File: rtl/s_demux_pkg.sv
// Shared types and defaults for the frame demultiplexer.
// Holds the FSM state enum, default sizes and the channel index type.
package s_demux_pkg;

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   localparam int DEF_WIDTH    = 24;
   localparam int DEF_CHANNELS = 32;

   typedef logic [4:0] chan_t;

endpackage

// File: rtl/s_demux_timer.sv
// Mid-frame idle timeout counter for s_demux_frame.
// Ports: Clk, nReset, Active (FSM in COLLECT), Valid (sample this cycle),
//        Hit (abort request: count reaches TIMEOUT without a sample).
module s_demux_timer
   import s_demux_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic Clk,
   input  logic nReset,
   input  logic Active,
   input  logic Valid,
   output logic Hit
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Counts idle COLLECT cycles; any sample or leaving COLLECT clears it.
   always_comb begin
      cnt_d = '0;
      if (Active && !Valid) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Fires on the idle cycle that would bring the count to TIMEOUT;
   // a sample in that cycle wins because Valid masks the compare.
   assign Hit = Active && !Valid && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/s_demux_frame.sv
// Frame demultiplexer: splits a channel-multiplexed sample stream into a
// shadow bank and commits complete frames atomically to Output.
// Ports: Clk, nReset (async, active-low), In_Data/In_Valid/In_Start (stream),
//        Output (channel n at [n*WIDTH +: WIDTH]), Frame_Valid / Frame_Err
//        (one-cycle pulses), Channel (next write index).
// Build option: S_DEMUX_TIMEOUT_EN adds a mid-frame idle timeout.
module s_demux_frame
   import s_demux_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int TIMEOUT  = 1024
) (
   input  logic                      Clk,
   input  logic                      nReset,
   input  logic [WIDTH-1:0]          In_Data,
   input  logic                      In_Valid,
   input  logic                      In_Start,
   output logic [CHANNELS*WIDTH-1:0] Output,
   output logic                      Frame_Valid,
   output logic                      Frame_Err,
   output logic [4:0]                Channel
);

   localparam chan_t LAST = chan_t'(CHANNELS - 1);

   state_t                    state_q, state_d;
   chan_t                     chan_q, chan_d;
   logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
   logic [CHANNELS*WIDTH-1:0] out_q, out_d;
   logic                      fv_q, fv_d;
   logic                      fe_q, fe_d;

   logic                      wr_en;
   chan_t                     wr_idx;
   logic                      tmo_hit;

`ifdef S_DEMUX_TIMEOUT_EN
   s_demux_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .Clk    (Clk),
      .nReset (nReset),
      .Active (state_q == COLLECT),
      .Valid  (In_Valid),
      .Hit    (tmo_hit)
   );
`else
   // No timeout: COLLECT waits indefinitely.
   assign tmo_hit = (TIMEOUT < 0);
`endif

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      fv_d     = 1'b0;
      fe_d     = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = chan_q;

      unique case (state_q)
         IDLE: begin
            if (In_Valid && In_Start) begin
               wr_en  = 1'b1;
               wr_idx = '0;
            end
         end
         COLLECT: begin
            if (In_Valid) begin
               wr_en = 1'b1;
               // Early restart drops the partial frame.
               if (In_Start) begin
                  fe_d   = 1'b1;
                  wr_idx = '0;
               end
            end else if (tmo_hit) begin
               fe_d    = 1'b1;
               chan_d  = '0;
               state_d = IDLE;
            end
         end
      endcase

      if (wr_en) begin
         shadow_d[int'(wr_idx)*WIDTH +: WIDTH] = In_Data;
         // Commit includes the sample written this cycle.
         if (wr_idx == LAST) begin
            out_d   = shadow_d;
            fv_d    = 1'b1;
            chan_d  = '0;
            state_d = IDLE;
         end else begin
            chan_d  = wr_idx + chan_t'(1);
            state_d = COLLECT;
         end
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q  <= IDLE;
         chan_q   <= '0;
         shadow_q <= '0;
         out_q    <= '0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
      end
   end

   assign Output      = out_q;
   assign Frame_Valid = fv_q;
   assign Frame_Err   = fe_q;
   assign Channel     = chan_q;

endmodule

// File: tb/tb_s_demux_frame.sv
// Directed bench for s_demux_frame.
// Vector table for single-cycle behaviour plus multi-cycle frame sequences.
module tb_s_demux_frame;

   localparam int CH = 32;
   localparam int W  = 24;

   logic          Clk = 1'b0;
   logic          nReset = 1'b0;
   logic [W-1:0]  In_Data = '0;
   logic          In_Valid = 1'b0;
   logic          In_Start = 1'b0;
   logic [CH*W-1:0] Output;
   logic          Frame_Valid;
   logic          Frame_Err;
   logic [4:0]    Channel;

   int errors = 0;
   int checks = 0;

   s_demux_frame #(
      .CHANNELS (CH),
      .WIDTH    (W),
      .TIMEOUT  (16)
   ) dut (
      .Clk         (Clk),
      .nReset      (nReset),
      .In_Data     (In_Data),
      .In_Valid    (In_Valid),
      .In_Start    (In_Start),
      .Output      (Output),
      .Frame_Valid (Frame_Valid),
      .Frame_Err   (Frame_Err),
      .Channel     (Channel)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic         v;
      logic         s;
      logic [W-1:0] d;
      logic         fv;
      logic         fe;
      logic [4:0]   ch;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int slot(int n);
      return int'(Output[n*W +: W]);
   endfunction

   task automatic cyc(logic v, logic s, logic [W-1:0] d);
      In_Valid = v;
      In_Start = s;
      In_Data  = d;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      In_Valid = 1'b0;
      In_Start = 1'b0;
      In_Data  = '0;
      nReset   = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      nReset = 1'b1;
   endtask

   initial begin
      int fv1;
      int fv2;

      tbl[0] = '{1'b1, 1'b0, 24'h000005, 1'b0, 1'b0, 5'd0};
      tbl[1] = '{1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 5'd0};
      tbl[2] = '{1'b1, 1'b1, 24'h00000A, 1'b0, 1'b0, 5'd1};
      tbl[3] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 5'd1};
      tbl[4] = '{1'b1, 1'b0, 24'h00000B, 1'b0, 1'b0, 5'd2};
      tbl[5] = '{1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 5'd2};
      tbl[6] = '{1'b1, 1'b1, 24'h00000C, 1'b0, 1'b1, 5'd1};
      tbl[7] = '{1'b1, 1'b0, 24'h00000D, 1'b0, 1'b0, 5'd2};
      tbl[8] = '{1'b1, 1'b1, 24'h00000E, 1'b0, 1'b1, 5'd1};

      // Reset state
      do_reset();
      chk("rst_out", int'(|Output), 0);
      chk("rst_fv", int'(Frame_Valid), 0);
      chk("rst_fe", int'(Frame_Err), 0);
      chk("rst_ch", int'(Channel), 0);

      // Table vectors
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].v, tbl[i].s, tbl[i].d);
         chk($sformatf("tbl%0d_fv", i), int'(Frame_Valid), int'(tbl[i].fv));
         chk($sformatf("tbl%0d_fe", i), int'(Frame_Err), int'(tbl[i].fe));
         chk($sformatf("tbl%0d_ch", i), int'(Channel), int'(tbl[i].ch));
      end
      chk("tbl_out", int'(|Output), 0);

      // Full contiguous frame
      do_reset();
      for (int i = 0; i < CH; i++) begin
         cyc(1'b1, i == 0, W'(i + 1));
         chk("ff_ch", int'(Channel), (i + 1) % CH);
         chk("ff_fv", int'(Frame_Valid), int'(i == CH - 1));
         chk("ff_fe", int'(Frame_Err), 0);
      end
      for (int n = 0; n < CH; n++) chk($sformatf("ff_out%0d", n), slot(n), n + 1);
      cyc(1'b0, 1'b0, '0);
      chk("ff_fv_pulse", int'(Frame_Valid), 0);

      // Gapped frame
      for (int i = 0; i < CH; i++) begin
         cyc(1'b1, i == 0, W'(i + 1));
         chk("gap_ch", int'(Channel), (i + 1) % CH);
         chk("gap_fv", int'(Frame_Valid), int'(i == CH - 1));
         if (i < CH - 1) begin
            cyc(1'b0, 1'b0, '0);
            chk("gap_idle_ch", int'(Channel), i + 1);
            chk("gap_idle_fv", int'(Frame_Valid), 0);
         end
      end
      chk("gap_out0", slot(0), 1);
      chk("gap_out31", slot(31), 32);

      // Early restart
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, i == 0, W'(32'h100 + i));
         chk("er_fe_pre", int'(Frame_Err), 0);
      end
      cyc(1'b1, 1'b1, 24'hFFFFFF);
      chk("er_fe", int'(Frame_Err), 1);
      chk("er_fv", int'(Frame_Valid), 0);
      chk("er_ch", int'(Channel), 1);
      chk("er_keep", slot(0), 1);
      for (int i = 0; i < CH - 1; i++) begin
         cyc(1'b1, 1'b0, 24'h800000);
         chk("er_fv2", int'(Frame_Valid), int'(i == CH - 2));
         chk("er_fe2", int'(Frame_Err), 0);
      end
      chk("er_out0", slot(0), 32'hFFFFFF);
      for (int n = 1; n < CH; n++) chk($sformatf("er_out%0d", n), slot(n), 32'h800000);

      // Back-to-back frames
      fv1 = -1;
      fv2 = -1;
      for (int i = 0; i < 2 * CH; i++) begin
         cyc(1'b1, (i % CH) == 0,
             W'(((i < CH) ? 32'h10000 : 32'h20000) + (i % CH)));
         chk("b2b_fe", int'(Frame_Err), 0);
         if (Frame_Valid) begin
            if (fv1 < 0) fv1 = i;
            else fv2 = i;
         end
      end
      chk("b2b_first", fv1, CH - 1);
      chk("b2b_gap", fv2 - fv1, CH);
      for (int n = 0; n < CH; n += 7) chk($sformatf("b2b_out%0d", n), slot(n), 32'h20000 + n);

      // Reset mid-frame
      for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, W'(32'h55 + i));
      chk("rm_ch_pre", int'(Channel), 5);
      In_Valid = 1'b0;
      In_Start = 1'b0;
      #2 nReset = 1'b0;
      #1;
      chk("rm_out", int'(|Output), 0);
      chk("rm_ch", int'(Channel), 0);
      @(posedge Clk);
      #1 nReset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, W'(32'h60 + i));
         chk("rm_ign_ch", int'(Channel), 0);
      end
      cyc(1'b1, 1'b1, 24'h000077);
      chk("rm_start_ch", int'(Channel), 1);

`ifdef S_DEMUX_TIMEOUT_EN
      // Timeout abort and no-abort boundary
      do_reset();
      for (int i = 0; i < CH; i++) cyc(1'b1, i == 0, W'(32'h400 + i));
      chk("to_commit", slot(0), 32'h400);
      for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, W'(i + 1));
      chk("to_ch3", int'(Channel), 3);
      for (int k = 1; k < 16; k++) begin
         cyc(1'b0, 1'b0, '0);
         chk("to_wait_fe", int'(Frame_Err), 0);
         chk("to_wait_ch", int'(Channel), 3);
      end
      cyc(1'b0, 1'b0, '0);
      chk("to_fe", int'(Frame_Err), 1);
      chk("to_fv", int'(Frame_Valid), 0);
      chk("to_ch0", int'(Channel), 0);
      chk("to_keep", slot(0), 32'h400);
      cyc(1'b0, 1'b0, '0);
      chk("to_fe_pulse", int'(Frame_Err), 0);
      for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, W'(i + 1));
      for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 24'h000009);
      chk("nt_fe", int'(Frame_Err), 0);
      chk("nt_ch", int'(Channel), 4);
      cyc(1'b0, 1'b0, '0);
      chk("nt_fe2", int'(Frame_Err), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
